// File: rtl/sap1_pkg.sv
// Shared definitions for the SAP-1 memory slice.
//   DEFAULT_DATA_WIDTH / DEFAULT_ADDR_WIDTH : default word and address widths
//   RAM_DEPTH                               : word count for the default address width
//   ram_state_t                             : RAM controller states
package sap1_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned DEFAULT_ADDR_WIDTH = 4;
  localparam int unsigned RAM_DEPTH          = 1 << DEFAULT_ADDR_WIDTH;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    PROG  = 2'd2,
    DONE  = 2'd3
  } ram_state_t;

endpackage

// File: rtl/ram_array.sv
// Storage array for random_access_memory: one synchronous write port and one
// registered read port.
// Optional macro RAM_PARITY_EN: each word carries an even-parity bit written
// alongside the data; a read whose stored word fails parity raises parity_err
// for that one cycle.
// Ports:
//   clk, reset   : clock, synchronous active-high reset (clears read registers only)
//   we/waddr/wdata : write port
//   re/raddr     : read request; rdata holds its value when re is low
//   rdata        : registered read data
//   parity_err   : registered parity mismatch flag (tied 0 without the macro)
module ram_array
  import sap1_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  parity_err
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;
`ifdef RAM_PARITY_EN
  localparam int unsigned StoreWidth = DATA_WIDTH + 1;
`else
  localparam int unsigned StoreWidth = DATA_WIDTH;
`endif

  logic [StoreWidth-1:0] mem_q [Depth];
  logic [StoreWidth-1:0] store_word;
  logic [StoreWidth-1:0] read_word;
  logic [DATA_WIDTH-1:0] rdata_q;

`ifdef RAM_PARITY_EN
  // Parity bit sits above the data so the XOR of a healthy word is always 0.
  assign store_word = {^wdata, wdata};
`else
  assign store_word = wdata;
`endif

  assign read_word = mem_q[raddr];

  // Array itself is not reset; the controller zeroes it word by word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= store_word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= read_word[DATA_WIDTH-1:0];
    end
  end

  assign rdata = rdata_q;

`ifdef RAM_PARITY_EN
  logic parity_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= re & (^read_word);
    end
  end

  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: rtl/random_access_memory.sv
// SAP-1 16x8 program/data RAM sitting behind the memory address register.
// After every reset the controller zeroes the whole array (one word per cycle,
// o_busy high), then serves 1-cycle-latency reads on i_ce, or, on i_prog,
// loads all words in address order from a valid/ready byte stream.
// Optional macro RAM_PARITY_EN: per-word even parity with a read-time error flag.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   i_address, i_ce            : read address and read enable (idle only)
//   o_data, o_data_valid       : registered read data, pulse when o_data updated
//   i_prog                     : program-mode request (wins over i_ce)
//   i_prog_data, i_prog_valid  : loader byte stream
//   o_prog_ready               : loader byte accepted this cycle when valid
//   o_prog_addr                : next address the loader writes
//   o_prog_done                : one-cycle pulse after the last word is written
//   o_busy                     : array clear in progress
//   o_parity_err               : read parity mismatch (0 without the macro)
module random_access_memory
  import sap1_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] i_address,
  input  logic                  i_ce,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_data_valid,
  input  logic                  i_prog,
  input  logic [DATA_WIDTH-1:0] i_prog_data,
  input  logic                  i_prog_valid,
  output logic                  o_prog_ready,
  output logic [ADDR_WIDTH-1:0] o_prog_addr,
  output logic                  o_prog_done,
  output logic                  o_busy,
  output logic                  o_parity_err
);

  localparam logic [ADDR_WIDTH-1:0] LastAddr = {ADDR_WIDTH{1'b1}};

  ram_state_t            state_q;
  logic [ADDR_WIDTH-1:0] clr_ptr_q;
  logic [ADDR_WIDTH-1:0] prog_addr_q;
  logic                  prog_done_q;
  logic                  busy_q;
  logic                  data_valid_q;

  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  re;
  logic                  prog_accept;

  assign o_prog_ready = (state_q == PROG) && i_prog;
  assign prog_accept  = o_prog_ready && i_prog_valid;
  // Reads only in idle, and a simultaneous program request takes priority.
  assign re           = !reset && (state_q == IDLE) && i_ce && !i_prog;

  always_comb begin
    we    = 1'b0;
    waddr = clr_ptr_q;
    wdata = '0;
    if (!reset) begin
      if (state_q == CLEAR) begin
        we    = 1'b1;
        waddr = clr_ptr_q;
        wdata = '0;
      end else if (prog_accept) begin
        we    = 1'b1;
        waddr = prog_addr_q;
        wdata = i_prog_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= CLEAR;
      clr_ptr_q    <= '0;
      prog_addr_q  <= '0;
      prog_done_q  <= 1'b0;
      busy_q       <= 1'b1;
      data_valid_q <= 1'b0;
    end else begin
      prog_done_q  <= 1'b0;
      data_valid_q <= re;
      unique case (state_q)
        CLEAR: begin
          clr_ptr_q <= clr_ptr_q + 1'b1;
          if (clr_ptr_q == LastAddr) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        IDLE: begin
          if (i_prog) begin
            state_q     <= PROG;
            prog_addr_q <= '0;
          end
        end
        PROG: begin
          if (!i_prog) begin
            // Aborted load: keep written words, restart next time at 0.
            state_q     <= IDLE;
            prog_addr_q <= '0;
          end else if (i_prog_valid) begin
            if (prog_addr_q == LastAddr) begin
              prog_done_q <= 1'b1;
              prog_addr_q <= '0;
              state_q     <= DONE;
            end else begin
              prog_addr_q <= prog_addr_q + 1'b1;
            end
          end
        end
        DONE: begin
          if (!i_prog) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

  ram_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk       (clk),
    .reset     (reset),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .re        (re),
    .raddr     (i_address),
    .rdata     (o_data),
    .parity_err(o_parity_err)
  );

  assign o_data_valid = data_valid_q;
  assign o_prog_addr  = prog_addr_q;
  assign o_prog_done  = prog_done_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_random_access_memory.sv
module tb_random_access_memory;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] i_address;
  logic       i_ce;
  logic [7:0] o_data;
  logic       o_data_valid;
  logic       i_prog;
  logic [7:0] i_prog_data;
  logic       i_prog_valid;
  logic       o_prog_ready;
  logic [3:0] o_prog_addr;
  logic       o_prog_done;
  logic       o_busy;
  logic       o_parity_err;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  random_access_memory dut (
    .clk         (clk),
    .reset       (reset),
    .i_address   (i_address),
    .i_ce        (i_ce),
    .o_data      (o_data),
    .o_data_valid(o_data_valid),
    .i_prog      (i_prog),
    .i_prog_data (i_prog_data),
    .i_prog_valid(i_prog_valid),
    .o_prog_ready(o_prog_ready),
    .o_prog_addr (o_prog_addr),
    .o_prog_done (o_prog_done),
    .o_busy      (o_busy),
    .o_parity_err(o_parity_err)
  );

  // ---------------- behavioural reference ----------------
  // Phases of the memory as seen from outside.
  localparam int PhClear = 0, PhIdle = 1, PhLoad = 2, PhLoaded = 3;

  int         m_phase;
  int         m_clear_left;
  int         m_load_idx;
  logic [7:0] m_mem [16];
  bit         m_corrupt [16];
  logic [7:0] e_data;
  bit         e_valid, e_done, e_busy, e_perr;

  always @(posedge clk) begin
    e_valid = 1'b0;
    e_done  = 1'b0;
    e_perr  = 1'b0;
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        m_mem[i]     = 8'h00;
        m_corrupt[i] = 1'b0;
      end
      m_phase      = PhClear;
      m_clear_left = 16;
      m_load_idx   = 0;
      e_busy       = 1'b1;
      e_data       = 8'h00;
    end else begin
      case (m_phase)
        PhClear: begin
          m_clear_left = m_clear_left - 1;
          if (m_clear_left == 0) begin
            m_phase = PhIdle;
            e_busy  = 1'b0;
          end
        end
        PhIdle: begin
          if (i_prog) begin
            m_phase    = PhLoad;
            m_load_idx = 0;
          end else if (i_ce) begin
            e_data  = m_mem[i_address];
            e_valid = 1'b1;
`ifdef RAM_PARITY_EN
            e_perr  = m_corrupt[i_address];
`endif
          end
        end
        PhLoad: begin
          if (!i_prog) begin
            m_phase    = PhIdle;
            m_load_idx = 0;
          end else if (i_prog_valid) begin
            m_mem[m_load_idx]     = i_prog_data;
            m_corrupt[m_load_idx] = 1'b0;
            if (m_load_idx == 15) begin
              e_done     = 1'b1;
              m_load_idx = 0;
              m_phase    = PhLoaded;
            end else begin
              m_load_idx = m_load_idx + 1;
            end
          end
        end
        default: begin
          if (!i_prog) m_phase = PhIdle;
        end
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(o_busy), 32'(e_busy));
      chk("data_valid", 32'(o_data_valid), 32'(e_valid));
      chk("data", 32'(o_data), 32'(e_data));
      chk("prog_addr", 32'(o_prog_addr), 32'(m_load_idx));
      chk("prog_done", 32'(o_prog_done), 32'(e_done));
      chk("prog_ready", 32'(o_prog_ready), 32'((m_phase == PhLoad) && i_prog));
      chk("parity_err", 32'(o_parity_err), 32'(e_perr));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_clear(input int want_cycles);
    int n = 0;
    @(negedge clk);
    while (o_busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("clear_length", 32'(n), 32'(want_cycles));
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic read_lit(input logic [3:0] addr, input logic [7:0] want);
    i_address = addr;
    i_ce      = 1'b1;
    tick();
    i_ce = 1'b0;
    chk("read_lit_valid", 32'(o_data_valid), 32'd1);
    chk("read_lit_data", 32'(o_data), 32'(want));
  endtask

  // Streams n bytes base+k; gaps inserts an idle valid cycle after each byte.
  task automatic load(input int n, input logic [7:0] base, input bit gaps);
    i_prog = 1'b1;
    tick();
    for (int k = 0; k < n; k++) begin
      i_prog_valid = 1'b1;
      i_prog_data  = base + 8'(k);
      tick();
      i_prog_valid = 1'b0;
      if (k == 15) begin
        chk("done_pulse", 32'(o_prog_done), 32'd1);
        chk("addr_wrap", 32'(o_prog_addr), 32'd0);
      end else begin
        chk("no_done", 32'(o_prog_done), 32'd0);
        chk("addr_step", 32'(o_prog_addr), 32'(k + 1));
      end
      if (gaps && k != 15) begin
        tick();
        chk("gap_hold", 32'(o_prog_addr), 32'(k + 1));
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    i_address = 4'h0; i_ce = 1'b0;
    i_prog = 1'b0; i_prog_data = 8'h00; i_prog_valid = 1'b0;
    tick();
    chk_en = 1'b1;
    reset  = 1'b0;

    // 1: clear length and a zero read
    wait_clear(16);
    read_lit(4'h5, 8'h00);

    // 2: back-to-back load 10..1F, read E
    load(16, 8'h10, 1'b0);
    i_prog = 1'b0;
    tick();
    read_lit(4'hE, 8'h1E);

    // 3: load with gaps, final contents
    load(16, 8'h10, 1'b1);
    i_prog = 1'b0;
    tick();
    for (int a = 0; a < 16; a++) read_lit(4'(a), 8'h10 + 8'(a));

    // 4: aborted load keeps written words, restart at 0
    load(5, 8'hA0, 1'b0);
    i_prog = 1'b0;
    tick();
    for (int a = 0; a < 5; a++) read_lit(4'(a), 8'hA0 + 8'(a));
    read_lit(4'h5, 8'h15);
    i_prog = 1'b1;
    tick();
    chk("reentry_addr", 32'(o_prog_addr), 32'd0);
    i_prog = 1'b0;
    tick();

    // 5: reset mid-load re-zeroes everything
    load(8, 8'h55, 1'b0);
    i_prog = 1'b0;
    do_reset();
    wait_clear(16);
    for (int a = 0; a < 16; a++) read_lit(4'(a), 8'h00);

`ifdef RAM_PARITY_EN
    // 6: corrupt bit 0 of word 3
    dut.u_array.mem_q[3] = dut.u_array.mem_q[3] ^ 9'h001;
    m_mem[3]     = m_mem[3] ^ 8'h01;
    m_corrupt[3] = 1'b1;
    read_lit(4'h3, 8'h01);
    chk("parity_hit", 32'(o_parity_err), 32'd1);
    read_lit(4'h2, 8'h00);
    chk("parity_clean", 32'(o_parity_err), 32'd0);
`endif

    // Random traffic against the model
    for (int c = 0; c < 1500; c++) begin
      reset        = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 19) == 0) i_prog = ~i_prog;
      i_prog_valid = $urandom_range(0, 2) != 0;
      i_prog_data  = 8'($urandom);
      i_ce         = $urandom_range(0, 1) != 0;
      i_address    = 4'($urandom);
      tick();
    end
    reset = 1'b0; i_prog = 1'b0; i_ce = 1'b0; i_prog_valid = 1'b0;
    tick();
    tick();
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
